soc_mem_arbiter: RTL and testbench

//  Shares the single-ported SoC memory between the core's instruction-fetch port (m0)
//  and its load/store port (m1), with round-robin arbitration.

---
 rtl/soc_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_soc_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_mem_arbiter
// Brief    : Round-robin arbiter sharing one single-ported memory between the
//            instruction-fetch master (m0) and the load/store master (m1).
//            One transaction outstanding at a time; responses are routed back
//            to the issuing master, and a missing response becomes an error
//            after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module soc_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // master 0 (instruction fetch)
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rerr_o,
  // master 1 (load/store)
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rerr_o,
  // memory side
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  // Counter just wide enough to reach TIMEOUT-1
  localparam int                 c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_owner;
  logic                  r_owner;
  logic                  r_mem_req;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_m0_rvalid;
  logic                  r_m1_rvalid;
  logic [DATA_W-1:0]     r_m0_rdata;
  logic [DATA_W-1:0]     r_m1_rdata;
  logic                  r_m0_rerr;
  logic                  r_m1_rerr;

  logic                  w_pick;
  logic                  w_sel_we;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wdata;
  logic [DATA_W/8-1:0]   w_sel_wstrb;
  logic                  w_rsp_fire;
  logic                  w_rsp_err;
  logic [DATA_W-1:0]     w_rsp_data;
  logic                  w_issue_gnt;

  // Arbitration: a lone requester wins; on a tie the master not served last wins
  always_comb begin
    w_pick = m1_req_i;
    if (m0_req_i && m1_req_i) begin
      w_pick = ~r_last_owner;
    end
    w_sel_we    = w_pick ? m1_we_i    : m0_we_i;
    w_sel_addr  = w_pick ? m1_addr_i  : m0_addr_i;
    w_sel_wdata = w_pick ? m1_wdata_i : m0_wdata_i;
    w_sel_wstrb = w_pick ? m1_wstrb_i : m0_wstrb_i;
  end

  // Response decision in WAIT: a real response beats the timeout on the last cycle
  always_comb begin
    w_rsp_fire = (r_state == ST_WAIT) && (mem_rvalid_i || (r_cnt == c_CNT_LAST));
    w_rsp_err  = ~mem_rvalid_i;
    w_rsp_data = mem_rvalid_i ? mem_rdata_i : '0;
  end

  // Transaction FSM with registered memory request and master responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_cnt        <= '0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_rerr    <= 1'b0;
      r_m1_rerr    <= 1'b0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m0_req_i || m1_req_i) begin
            r_owner   <= w_pick;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_wstrb   <= w_sel_wstrb;
            r_mem_req <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_rsp_fire) begin
            if (r_owner) begin
              r_m1_rvalid <= 1'b1;
              r_m1_rdata  <= w_rsp_data;
              r_m1_rerr   <= w_rsp_err;
            end else begin
              r_m0_rvalid <= 1'b1;
              r_m0_rdata  <= w_rsp_data;
              r_m0_rerr   <= w_rsp_err;
            end
            r_last_owner <= r_owner;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant is the memory's acceptance passed straight through to the owner
  assign w_issue_gnt = r_mem_req & mem_gnt_i;
  assign m0_gnt_o    = w_issue_gnt & ~r_owner;
  assign m1_gnt_o    = w_issue_gnt &  r_owner;

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;

  assign m0_rvalid_o = r_m0_rvalid;
  assign m1_rvalid_o = r_m1_rvalid;
  assign m0_rdata_o  = r_m0_rdata;
  assign m1_rdata_o  = r_m1_rdata;
  assign m0_rerr_o   = r_m0_rerr;
  assign m1_rerr_o   = r_m1_rerr;

endmodule
`default_nettype wire

// File: tb/tb_soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_mem_arbiter
// Brief    : Scoreboard bench for soc_mem_arbiter with a behavioural memory
//            whose grant delay, response delay and silence are programmable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_mem_arbiter;

  localparam int          c_TIMEOUT = 16;
  localparam logic [31:0] c_PAT     = 32'h5A5A_A5A5;

  typedef struct packed {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  typedef struct packed {
    logic        m;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk, rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_rerr_o, m1_gnt_o, m1_rvalid_o, m1_rerr_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wstrb_o;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t exp_i;
  rsp_t exp_r;

  int n_chk, n_fail;
  int cyc, gnt_count, req_hi_cnt, last_gnt_cyc, last_rv_cyc;

  // memory model controls
  int          gnt_delay, resp_delay, req_cnt, resp_cnt;
  bit          respond, resp_pending, use_fixed, late_pulse;
  logic [31:0] fixed_data, pend_data;

  soc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(c_TIMEOUT)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m0_rerr_o(m0_rerr_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .m1_rerr_o(m1_rerr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model: grants after gnt_delay request cycles, answers resp_delay cycles later
  always @(posedge clk) begin
    cyc++;
    #1;
    mem_rvalid_i = 1'b0;
    if (late_pulse) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_BAD0;
      late_pulse   = 1'b0;
    end
    if (resp_pending) begin
      if (resp_cnt <= 1) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend_data;
        resp_pending = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    if (mem_req_o) begin
      if (req_cnt >= gnt_delay) begin
        mem_gnt_i = 1'b1;
        req_cnt   = 0;
        if (respond) begin
          resp_pending = 1'b1;
          resp_cnt     = resp_delay;
          pend_data    = use_fixed ? fixed_data : (mem_addr_o ^ c_PAT);
        end
      end else begin
        mem_gnt_i = 1'b0;
        req_cnt++;
      end
    end else begin
      mem_gnt_i = 1'b0;
      req_cnt   = 0;
    end
  end

  // Scoreboard monitor: issue queue checked at grants, response queue at rvalid
  always @(negedge clk) begin
    if (mem_req_o) begin
      req_hi_cnt++;
      if (iss_q.size() == 0) chk("mem_req_unexpected", mem_req_o, 0);
      else chk("mem_fields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o},
               {iss_q[0].we, iss_q[0].addr, iss_q[0].wdata, iss_q[0].wstrb});
    end
    if (m0_gnt_o || m1_gnt_o) begin
      gnt_count++;
      last_gnt_cyc = cyc;
      if (iss_q.size() == 0) chk("gnt_unexpected", {m1_gnt_o, m0_gnt_o}, 0);
      else begin
        exp_i = iss_q.pop_front();
        chk("gnt_owner", {m1_gnt_o, m0_gnt_o}, exp_i.m ? 2'b10 : 2'b01);
      end
    end
    if (m0_rvalid_o || m1_rvalid_o) begin
      last_rv_cyc = cyc;
      if (rsp_q.size() == 0) chk("rsp_unexpected", {m1_rvalid_o, m0_rvalid_o}, 0);
      else begin
        exp_r = rsp_q.pop_front();
        chk("rsp_owner", {m1_rvalid_o, m0_rvalid_o}, exp_r.m ? 2'b10 : 2'b01);
        chk("rsp_data", exp_r.m ? m1_rdata_o : m0_rdata_o, exp_r.data);
        chk("rsp_err", exp_r.m ? m1_rerr_o : m0_rerr_o, exp_r.err);
      end
    end
  end

  task automatic push_txn(input bit m, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input bit err, input bit with_rsp);
    iss_t it;
    rsp_t rt;
    it = '{m: m, we: we, addr: addr, wdata: wdata, wstrb: strb};
    iss_q.push_back(it);
    if (with_rsp) begin
      rt.m    = m;
      rt.err  = err;
      rt.data = err ? 32'h0 : (use_fixed ? fixed_data : (addr ^ c_PAT));
      rsp_q.push_back(rt);
    end
  endtask

  task automatic set_master(input bit m, input bit req, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
    if (m) begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata; m1_wstrb_i = strb;
    end else begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata; m0_wstrb_i = strb;
    end
  endtask

  // Single request: hold until this master's grant, then drop
  task automatic drive(input bit m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input bit err, input bit with_rsp);
    int n;
    logic g;
    push_txn(m, we, addr, wdata, strb, err, with_rsp);
    set_master(m, 1'b1, we, addr, wdata, strb);
    n = 0;
    g = 1'b0;
    while (!g && n < 200) begin
      @(negedge clk);
      g = m ? m1_gnt_o : m0_gnt_o;
      n++;
    end
    if (!g) chk("gnt_wait_timeout", g, 1);
    @(posedge clk);
    #1;
    if (m) m1_req_i = 1'b0; else m0_req_i = 1'b0;
  endtask

  task automatic wait_gnts(input int target);
    int n;
    n = 0;
    while (gnt_count < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (gnt_count < target) chk("gnt_count_timeout", gnt_count, target);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (iss_q.size() != 0 || rsp_q.size() != 0)
      chk("drain_timeout", iss_q.size() + rsp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {mem_req_o, mem_we_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o,
                        m1_rvalid_o, m0_rerr_o, m1_rerr_o}, 0);
    chk({tag, "_mem"}, {mem_addr_o, mem_wstrb_o}, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_rdata"}, {m0_rdata_o, m1_rdata_o}, 0);
  endtask

  initial begin
    int base;
    n_chk = 0; n_fail = 0; cyc = 0; gnt_count = 0; req_hi_cnt = 0;
    last_gnt_cyc = 0; last_rv_cyc = 0;
    gnt_delay = 0; resp_delay = 1; req_cnt = 0; resp_cnt = 0;
    respond = 1'b1; resp_pending = 1'b0; use_fixed = 1'b0; late_pulse = 1'b0;
    fixed_data = 32'h0; pend_data = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    rst_i = 1'b1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // 1: m0 read with exact cycle timing
    use_fixed  = 1'b1;
    fixed_data = 32'hDEAD_BEEF;
    push_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    set_master(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    chk("t1_req_at_N", mem_req_o, 0);
    @(negedge clk);
    chk("t1_req_at_N1", mem_req_o, 1);
    chk("t1_gnt_at_N1", {m1_gnt_o, m0_gnt_o}, 2'b01);
    @(posedge clk);
    #1;
    m0_req_i = 1'b0;
    @(negedge clk);
    chk("t1_rvalid_at_N2", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
    @(negedge clk);
    chk("t1_rvalid_at_N3", {m1_rvalid_o, m0_rvalid_o}, 2'b01);
    chk("t1_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    chk("t1_m1_idle", {m1_rerr_o, m1_rdata_o}, 0);
    @(negedge clk);
    chk("t1_rdata_held", m0_rdata_o, 32'hDEAD_BEEF);
    use_fixed = 1'b0;
    wait_done();

    // 2: both held from reset -> m0, m1, m0, m1
    do_reset();
    base = gnt_count;
    push_txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b1);
    push_txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b1);
    push_txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b1);
    push_txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b1);
    set_master(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    set_master(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
    wait_gnts(base + 4);
    @(posedge clk);
    #1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    wait_done();

    // 3: m1 write with grant delayed 3 cycles; fields must stay stable
    gnt_delay  = 3;
    resp_delay = 2;
    req_hi_cnt = 0;
    drive(1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0, 1'b1);
    wait_done();
    chk("t3_req_cycles", req_hi_cnt, 4);

    // Requester drops req right after being latched: transaction still completes
    gnt_delay = 2;
    push_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b1);
    set_master(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    m0_req_i = 1'b0;
    wait_done();

    // 4: memory never answers -> timeout error, late response ignored
    gnt_delay  = 0;
    resp_delay = 1;
    respond    = 1'b0;
    drive(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 1'b1);
    wait_done();
    chk("t4_timeout_latency", last_rv_cyc - last_gnt_cyc, c_TIMEOUT + 1);
    late_pulse = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_late_rdata_hold", {m0_rerr_o, m0_rdata_o}, {1'b1, 32'h0});

    // 5: async reset while in WAIT, then tie goes to m0
    drive(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk_all_zero("t5_async_rst");
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (c_TIMEOUT + 4) @(negedge clk);
    respond = 1'b1;
    base = gnt_count;
    push_txn(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 1'b1);
    push_txn(1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 1'b0, 1'b1);
    set_master(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    set_master(1'b1, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
    wait_gnts(base + 2);
    @(posedge clk);
    #1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    wait_done();

    repeat (4) @(negedge clk);
    chk("final_iss_q_empty", iss_q.size(), 0);
    chk("final_rsp_q_empty", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
